// File: rtl/ram_write_arbiter.sv
// Four-requester write arbiter feeding both write ports of a dual-port RAM.
// Round-robin search order; port 1 takes the next eligible requester whose
// address differs from the port-0 winner. All outputs are registered.
module ram_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    localparam int unsigned NUM_REQ   = 4,
    localparam int unsigned CNT_W     = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            iReqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
    output logic [NUM_REQ-1:0]            oReqAck,
    output logic                          oWriteEnable0,
    output logic                          oWriteEnable1,
    output logic [ADDR_WIDTH-1:0]         oWriteAddress0,
    output logic [ADDR_WIDTH-1:0]         oWriteAddress1,
    output logic [DATA_WIDTH-1:0]         oDataIn0,
    output logic [DATA_WIDTH-1:0]         oDataIn1,
    output logic [CNT_W-1:0]              oWriteCount
);

    localparam int unsigned PTR_W = 2;

    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  we0_q, we0_d;
    logic                  we1_q, we1_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic                  g0_vld, g1_vld;
    logic [PTR_W-1:0]      g0_idx, g1_idx, last_pos, idx;

    // Unpack the flat request buses into per-requester words.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req_addr[k] = iReqAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            req_data[k] = iReqData[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pick port-0 and port-1 winners in round-robin order; requesters acked
    // this cycle sit out so a held request is not written twice.
    always_comb begin
        eligible = iReqValid & ~ack_q;
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        last_pos = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr_q + PTR_W'(i);
            if (eligible[idx]) begin
                if (!g0_vld) begin
                    g0_vld   = 1'b1;
                    g0_idx   = idx;
                    last_pos = PTR_W'(i);
                end else if (!g1_vld && (req_addr[idx] != req_addr[g0_idx])) begin
                    g1_vld   = 1'b1;
                    g1_idx   = idx;
                    last_pos = PTR_W'(i);
                end
            end
        end
    end

    // Next-state values for the registered outputs, pointer and counter.
    always_comb begin
        ack_d   = '0;
        we0_d   = g0_vld;
        we1_d   = g1_vld;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        ptr_d   = ptr_q;
        count_d = count_q + CNT_W'(g0_vld) + CNT_W'(g1_vld);
        if (g0_vld) begin
            ack_d[g0_idx] = 1'b1;
            addr0_d       = req_addr[g0_idx];
            data0_d       = req_data[g0_idx];
            ptr_d         = ptr_q + last_pos + PTR_W'(1);
        end
        if (g1_vld) begin
            ack_d[g1_idx] = 1'b1;
            addr1_d       = req_addr[g1_idx];
            data1_d       = req_data[g1_idx];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ack_q   <= '0;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            we0_q   <= we0_d;
            we1_q   <= we1_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign oReqAck        = ack_q;
    assign oWriteEnable0  = we0_q;
    assign oWriteEnable1  = we1_q;
    assign oWriteAddress0 = addr0_q;
    assign oWriteAddress1 = addr1_q;
    assign oDataIn0       = data0_q;
    assign oDataIn1       = data1_q;
    assign oWriteCount    = count_q;

endmodule
